pcie_rx_snoop_xlat: RTL and testbench
=====================================

Name: pcie_rx_snoop_xlat

Overview:
Parametrised PCIe RX TLP snooper for the KC705 PCIe-to-XGMII bridge. It taps the 64-bit AXIS RX stream of the PCIe endpoint (passive, always ready) and selects TLPs that hit any enabled BAR window, plus all completions. It rewrites request addresses through a per-window physical page base and inverts the requester-ID nibble. Tagged 72-bit words go to the XGMII-TX FIFO, with whole-TLP drop on FIFO full and programmable inter-frame-gap insertion.

Parameters:
NUM_WIN, 4, number of BAR translation windows (1..4); window i hits on m_axis_rx_tuser[BAR_LSB+i]
BAR_LSB, 2, tuser bit index of BAR0 hit
GAP_CYCLES, 7, IFG words emitted per req_gap request (0..15; 0 disables gap insertion)

Ports:
clk  in  1  sole clock
sys_rst  in  1  synchronous, active-high reset
m_axis_rx_tdata  in  64  RX TLP data
m_axis_rx_tkeep  in  8  byte enables; only bits 0 and 4 are used
m_axis_rx_tlast  in  1  last beat of TLP
m_axis_rx_tvalid  in  1  beat valid
m_axis_rx_tready  out  1  constant 1
m_axis_rx_tuser  in  22  endpoint sideband (BAR hit bits)
win_paddr  in  NUM_WIN*36  per-window page base, window i = bits [36i+35:36i], maps to paddr[47:12]
win_en  in  NUM_WIN  per-window enable
req_gap  in  1  request IFG insertion (level-sampled each cycle)
din  out  72  FIFO write data
full  in  1  FIFO full
wr_en  out  1  FIFO write strobe
drop_cnt  out  16  TLPs dropped at SOF because full (saturating)
acc_cnt  out  32  TLPs accepted (wrapping)

Behaviour:
- Reset (clk edge with sys_rst=1): wr_en=0, din=0, drop_cnt=0, acc_cnt=0, gap_cnt=0, state=IDLE. Reset mid-TLP abandons the TLP; the remaining beats are treated as non-SOF traffic and are ignored until the next beat that follows a tlast.
- Data word format: [63:0] data, [64] tvalid, [65] tlast, [66] tkeep[0], [67] tkeep[4], [68] 0, [71:69] 3'b101.
- IFG word format: din = {3'b000, 1'b1, 68'h0}.
- Latency: every output word is registered exactly 1 cycle after its input beat. wr_en is 1 only on cycles carrying a word.
- Beats with tvalid=0 never produce writes and never advance state.
- Window select at SOF: hit = win_en & tuser[BAR_LSB+NUM_WIN-1:BAR_LSB]; lowest set index wins, latched as win for the whole TLP.
- Completion: tdata[28:24]==5'b01010.
- States: IDLE, HDR1, DATA, DROP.
- IDLE, tvalid, and (hit!=0 or completion):
  - full=1: go to DROP (or stay in IDLE if tlast); drop_cnt++ saturating at 16'hFFFF; no write.
  - full=0: write word 0; acc_cnt++; latch fmt=tdata[30:29], type=tdata[28:24], cpl flag. Non-completion: data[63:60] inverted; completion: data passed through. Next state HDR1, or IDLE if tlast.
- IDLE, tvalid, not selected: the beat is consumed and the TLP is ignored (a state tracks the non-selected TLP until tlast; no write).
- HDR1 (word 1 rewrite):
  - type[4:1]==4'b0000 and fmt[0]==0: {tdata[63:32], paddr[31:12], tdata[11:0]}
  - type[4:1]==4'b0000 and fmt[0]==1: {paddr[31:12], tdata[11:0], 16'h0, paddr[47:32]}, where paddr = win_paddr[win]
  - completion: {tdata[63:32], ~tdata[31:28], tdata[27:0]}
  - otherwise: pass through
  - Next state DATA, or IDLE if tlast.
- DATA: pass through; tlast returns to IDLE. full mid-TLP does not stop writes; FIFO sizing guarantees room once SOF is accepted.
- DROP: no writes; tlast returns to IDLE.
- Gap insertion:
  - req_gap=1 loads gap_cnt=GAP_CYCLES (reload if already nonzero).
  - In IDLE with gap_cnt!=0, full=0, and no SOF accepted this cycle: write one IFG word and decrement gap_cnt.
  - An accepted SOF has priority; the remaining gap is kept for after the TLP.
  - req_gap and decrement in the same cycle: the load wins.
  - No IFG is written while full=1 (gap_cnt held).

Optional Feature:
SNOOP_STATS_EN: defined -> drop_cnt and acc_cnt count as specified. Undefined -> both ports tied to constant 0 and counter logic removed; all other behaviour identical.

Test Plan:
1. 3DW MWr, 1 DW, tuser[4]=1, win_en=4'b0100, win_paddr[2]=36'h0_1234_5, addr 32'h0000_0ABC -> 2 writes; word1[31:0]=32'h1234_5ABC; word0[63:60] inverted; din[71:69]=3'b101; acc_cnt=1.
2. 4DW MRd, tuser[2] and tuser[3] both set, both windows enabled, win_paddr[0]=36'hA_BCDE_F -> window 0 used; word1 = {20'hBCDEF, addr[11:0], 16'h0, 16'h000A}.
3. CplD, 4 beats, no BAR hit -> 4 writes; word0 unchanged; word1[31:28] inverted; state back to IDLE after tlast.
4. full=1 at SOF of a 5-beat BAR TLP, then full=0 -> zero writes for that TLP; drop_cnt=1; the next TLP is written normally.
5. req_gap pulse, GAP_CYCLES=7, idle bus -> 7 consecutive IFG words din=72'h10_0000_0000_0000_0000. A selected SOF arriving after 3 IFG words is written first; the remaining 4 IFG words follow its tlast.
6. sys_rst asserted during DATA of a 6-beat TLP -> next cycle wr_en=0, din=0, counters 0; the tail beats produce no writes.

Source files
------------

// File: rtl/pcie_rx_snoop_xlat.sv
// PCIe RX TLP snooper: selects BAR-window hits and completions, rewrites headers, feeds XGMII-TX FIFO.
// Optional build macro SNOOP_STATS_EN enables the drop/accept statistics counters.
module pcie_rx_snoop_xlat #(
  parameter int unsigned NUM_WIN    = 4,
  parameter int unsigned BAR_LSB    = 2,
  parameter int unsigned GAP_CYCLES = 7
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic [63:0]            m_axis_rx_tdata,
  input  logic [7:0]             m_axis_rx_tkeep,
  input  logic                   m_axis_rx_tlast,
  input  logic                   m_axis_rx_tvalid,
  output logic                   m_axis_rx_tready,
  input  logic [21:0]            m_axis_rx_tuser,
  input  logic [NUM_WIN*36-1:0]  win_paddr,
  input  logic [NUM_WIN-1:0]     win_en,
  input  logic                   req_gap,
  output logic [71:0]            din,
  input  logic                   full,
  output logic                   wr_en,
  output logic [15:0]            drop_cnt,
  output logic [31:0]            acc_cnt
);

  localparam int unsigned WIN_W = (NUM_WIN > 1) ? $clog2(NUM_WIN) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_HDR1 = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_DROP = 2'd3;

  localparam logic [71:0] IFG_WORD = {3'b000, 1'b1, 68'h0};

  logic [1:0]       state_q, state_d;
  logic             skip_q, skip_d;
  logic [WIN_W-1:0] win_q, win_d;
  logic             mem_q, mem_d;
  logic             fmt4_q, fmt4_d;
  logic             cpl_q, cpl_d;
  logic [3:0]       gap_q, gap_d;
  logic [71:0]      din_q, din_d;
  logic             wr_en_q, wr_en_d;

  logic [NUM_WIN-1:0] hit;
  logic [WIN_W-1:0]   win_sel;
  logic [35:0]        pbase;
  logic               is_cpl;
  logic               sel;
  logic               sof_acc;
  logic               sof_drop;
  logic               ifg;
  logic [7:0]         tag;
  logic [63:0]        w1;
  logic               rst_skip;

  assign m_axis_rx_tready = 1'b1;
  assign din   = din_q;
  assign wr_en = wr_en_q;

  assign hit    = win_en & m_axis_rx_tuser[BAR_LSB +: NUM_WIN];
  assign is_cpl = (m_axis_rx_tdata[28:24] == 5'b01010);
  assign sel    = (|hit) | is_cpl;
  assign tag    = {3'b101, 1'b0, m_axis_rx_tkeep[4], m_axis_rx_tkeep[0],
                   m_axis_rx_tlast, m_axis_rx_tvalid};

  always_comb begin
    win_sel = '0;
    for (int unsigned i = NUM_WIN; i > 0; i--) begin
      if (hit[i-1]) win_sel = WIN_W'(i - 1);
    end
  end

  always_comb begin
    pbase = '0;
    for (int unsigned i = 0; i < NUM_WIN; i++) begin
      if (win_q == WIN_W'(i)) pbase = win_paddr[36*i +: 36];
    end
  end

  // Second header word: page base supplies paddr[47:12]
  always_comb begin
    if (mem_q) begin
      if (!fmt4_q) w1 = {m_axis_rx_tdata[63:32], pbase[19:0], m_axis_rx_tdata[11:0]};
      else         w1 = {pbase[19:0], m_axis_rx_tdata[11:0], 16'h0, pbase[35:20]};
    end else if (cpl_q) begin
      w1 = {m_axis_rx_tdata[63:32], ~m_axis_rx_tdata[31:28], m_axis_rx_tdata[27:0]};
    end else begin
      w1 = m_axis_rx_tdata;
    end
  end

  always_comb begin
    state_d  = state_q;
    skip_d   = skip_q;
    win_d    = win_q;
    mem_d    = mem_q;
    fmt4_d   = fmt4_q;
    cpl_d    = cpl_q;
    din_d    = din_q;
    wr_en_d  = 1'b0;
    sof_acc  = 1'b0;
    sof_drop = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (m_axis_rx_tvalid) begin
          if (skip_q) begin
            if (m_axis_rx_tlast) skip_d = 1'b0;
          end else if (sel) begin
            if (full) begin
              sof_drop = 1'b1;
              if (!m_axis_rx_tlast) state_d = S_DROP;
            end else begin
              sof_acc = 1'b1;
              wr_en_d = 1'b1;
              win_d   = win_sel;
              mem_d   = (m_axis_rx_tdata[28:25] == 4'b0000);
              fmt4_d  = m_axis_rx_tdata[29];
              cpl_d   = is_cpl;
              din_d   = is_cpl ? {tag, m_axis_rx_tdata}
                               : {tag, ~m_axis_rx_tdata[63:60], m_axis_rx_tdata[59:0]};
              if (!m_axis_rx_tlast) state_d = S_HDR1;
            end
          end else if (!m_axis_rx_tlast) begin
            state_d = S_DROP;
          end
        end
      end
      S_HDR1: begin
        if (m_axis_rx_tvalid) begin
          wr_en_d = 1'b1;
          din_d   = {tag, w1};
          state_d = m_axis_rx_tlast ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (m_axis_rx_tvalid) begin
          wr_en_d = 1'b1;
          din_d   = {tag, m_axis_rx_tdata};
          if (m_axis_rx_tlast) state_d = S_IDLE;
        end
      end
      default: begin
        if (m_axis_rx_tvalid && m_axis_rx_tlast) state_d = S_IDLE;
      end
    endcase

    ifg = (state_q == S_IDLE) && (gap_q != 4'd0) && !full && !sof_acc;
    if (ifg) begin
      wr_en_d = 1'b1;
      din_d   = IFG_WORD;
    end

    if (req_gap)  gap_d = 4'(GAP_CYCLES);
    else if (ifg) gap_d = gap_q - 4'd1;
    else          gap_d = gap_q;

    // Reset mid-TLP: remember bus framing so the tail is not mistaken for a SOF
    rst_skip = m_axis_rx_tvalid ? ~m_axis_rx_tlast : ((state_q != S_IDLE) | skip_q);
    if (sys_rst) skip_d = rst_skip;
  end

  always_ff @(posedge clk) begin
    skip_q <= skip_d;
    if (sys_rst) begin
      state_q <= S_IDLE;
      win_q   <= '0;
      mem_q   <= 1'b0;
      fmt4_q  <= 1'b0;
      cpl_q   <= 1'b0;
      gap_q   <= '0;
      din_q   <= '0;
      wr_en_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      mem_q   <= mem_d;
      fmt4_q  <= fmt4_d;
      cpl_q   <= cpl_d;
      gap_q   <= gap_d;
      din_q   <= din_d;
      wr_en_q <= wr_en_d;
    end
  end

`ifdef SNOOP_STATS_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [31:0] acc_cnt_q, acc_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (sof_drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 16'd1;
    acc_cnt_d = acc_cnt_q + 32'(sof_acc);
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      drop_cnt_q <= '0;
      acc_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      acc_cnt_q  <= acc_cnt_d;
    end
  end

  assign drop_cnt = drop_cnt_q;
  assign acc_cnt  = acc_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = sof_drop;
  assign drop_cnt = '0;
  assign acc_cnt  = '0;
`endif

  logic unused_bits;
  assign unused_bits = ^{m_axis_rx_tkeep[7:5], m_axis_rx_tkeep[3:1], m_axis_rx_tuser};

endmodule

// File: tb/tb_pcie_rx_snoop_xlat.sv
// Scoreboard bench for pcie_rx_snoop_xlat: directed TLPs, expected FIFO words queued, monitor compares.
module tb_pcie_rx_snoop_xlat;

  logic          clk = 1'b0;
  logic          sys_rst;
  logic [63:0]   m_axis_rx_tdata;
  logic [7:0]    m_axis_rx_tkeep;
  logic          m_axis_rx_tlast;
  logic          m_axis_rx_tvalid;
  logic          m_axis_rx_tready;
  logic [21:0]   m_axis_rx_tuser;
  logic [143:0]  win_paddr;
  logic [3:0]    win_en;
  logic          req_gap;
  logic [71:0]   din;
  logic          full;
  logic          wr_en;
  logic [15:0]   drop_cnt;
  logic [31:0]   acc_cnt;

`ifdef SNOOP_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  localparam logic [71:0] IFG = {3'b000, 1'b1, 68'h0};

  int total = 0;
  int bad   = 0;
  logic [71:0] exp_q[$];

  always #5 clk = ~clk;

  pcie_rx_snoop_xlat #(
    .NUM_WIN(4),
    .BAR_LSB(2),
    .GAP_CYCLES(7)
  ) dut (
    .clk(clk),
    .sys_rst(sys_rst),
    .m_axis_rx_tdata(m_axis_rx_tdata),
    .m_axis_rx_tkeep(m_axis_rx_tkeep),
    .m_axis_rx_tlast(m_axis_rx_tlast),
    .m_axis_rx_tvalid(m_axis_rx_tvalid),
    .m_axis_rx_tready(m_axis_rx_tready),
    .m_axis_rx_tuser(m_axis_rx_tuser),
    .win_paddr(win_paddr),
    .win_en(win_en),
    .req_gap(req_gap),
    .din(din),
    .full(full),
    .wr_en(wr_en),
    .drop_cnt(drop_cnt),
    .acc_cnt(acc_cnt)
  );

  function automatic logic [71:0] dw(input logic [63:0] d, input logic last, input logic [7:0] k);
    return {3'b101, 1'b0, k[4], k[0], last, 1'b1, d};
  endfunction

  function automatic logic [31:0] cnt(input int unsigned v);
    return STATS ? 32'(v) : 32'd0;
  endfunction

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic put(input logic [63:0] d, input logic last, input logic [7:0] k, input logic [21:0] u);
    m_axis_rx_tvalid = 1'b1;
    m_axis_rx_tdata  = d;
    m_axis_rx_tlast  = last;
    m_axis_rx_tkeep  = k;
    m_axis_rx_tuser  = u;
  endtask

  task automatic beat(input logic [63:0] d, input logic last, input logic [7:0] k, input logic [21:0] u);
    tick();
    put(d, last, k, u);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      m_axis_rx_tvalid = 1'b0;
      m_axis_rx_tlast  = 1'b0;
    end
  endtask

  // Monitor: every FIFO write must match the head of the expected queue
  initial begin
    logic [71:0] e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write actual=%h required=no_write", din);
        end else begin
          e = exp_q.pop_front();
          check("fifo_word", din, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    sys_rst = 1'b1;
    m_axis_rx_tdata = '0; m_axis_rx_tkeep = '0; m_axis_rx_tlast = 1'b0;
    m_axis_rx_tvalid = 1'b0; m_axis_rx_tuser = '0;
    win_en = '0; req_gap = 1'b0; full = 1'b0;
    win_paddr = {36'hF_FFFF_FFFF, 36'h0_0001_2345, 36'h9_8765_4321, 36'h0_00AB_CDEF};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_wr_en", {71'h0, wr_en}, 72'h0);
    check("reset_din", din, 72'h0);
    check("reset_drop", {56'h0, drop_cnt}, 72'h0);
    check("reset_acc", {40'h0, acc_cnt}, 72'h0);
    check("tready", {71'h0, m_axis_rx_tready}, 72'h1);
    tick();
    sys_rst = 1'b0;
    idle(2);

    // 3DW MWr via window 2
    win_en = 4'b0100;
    exp_q.push_back(dw(64'hF100_000F_4000_0001, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'hDEAD_BEEF_1234_5ABC, 1'b1, 8'hFF));
    beat(64'h0100_000F_4000_0001, 1'b0, 8'hFF, 22'h10);
    beat(64'hDEAD_BEEF_0000_0ABC, 1'b1, 8'hFF, 22'h10);
    idle(3);
    check("acc_t1", {40'h0, acc_cnt}, {40'h0, cnt(1)});

    // 4DW MRd, windows 0 and 1 both hit; lowest wins
    win_en = 4'b0011;
    exp_q.push_back(dw(64'hF200_000F_2000_0001, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'hBCDE_F567_0000_000A, 1'b1, 8'hFF));
    beat(64'h0200_000F_2000_0001, 1'b0, 8'hFF, 22'h0C);
    beat(64'h1111_2222_3333_4567, 1'b1, 8'hFF, 22'h0C);
    idle(3);

    // BAR hit on a disabled window: whole TLP ignored
    win_en = 4'b0100;
    beat(64'h0100_000F_4000_0002, 1'b0, 8'hFF, 22'h04);
    beat(64'h0000_0000_0000_0100, 1'b0, 8'hFF, 22'h04);
    beat(64'h4000_0001_0000_0000, 1'b1, 8'hFF, 22'h04);
    idle(3);
    check("acc_t2", {40'h0, acc_cnt}, {40'h0, cnt(2)});

    // CplD, no BAR hit, full raised mid-TLP
    exp_q.push_back(dw(64'h0300_0008_4A00_0002, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'h5555_6666_8777_8888, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'h0123_4567_89AB_CDEF, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'hFEDC_BA98_7654_3210, 1'b1, 8'h0F));
    beat(64'h0300_0008_4A00_0002, 1'b0, 8'hFF, 22'h0);
    beat(64'h5555_6666_7777_8888, 1'b0, 8'hFF, 22'h0);
    full = 1'b1;
    beat(64'h0123_4567_89AB_CDEF, 1'b0, 8'hFF, 22'h0);
    beat(64'hFEDC_BA98_7654_3210, 1'b1, 8'h0F, 22'h0);
    idle(1);
    full = 1'b0;
    idle(2);
    check("acc_t3", {40'h0, acc_cnt}, {40'h0, cnt(3)});

    // full at SOF: 5-beat TLP dropped, next TLP passes
    full = 1'b1;
    beat(64'h0100_000F_4000_0003, 1'b0, 8'hFF, 22'h10);
    beat(64'h0000_0000_0000_0200, 1'b0, 8'hFF, 22'h10);
    full = 1'b0;
    beat(64'h1111_1111_2222_2222, 1'b0, 8'hFF, 22'h10);
    beat(64'h3333_3333_4444_4444, 1'b0, 8'hFF, 22'h10);
    beat(64'h5555_5555_6666_6666, 1'b1, 8'hFF, 22'h10);
    exp_q.push_back(dw(64'hF100_000F_4000_0001, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'h1234_5678_1234_5FFF, 1'b1, 8'hFF));
    beat(64'h0100_000F_4000_0001, 1'b0, 8'hFF, 22'h10);
    beat(64'h1234_5678_0000_0FFF, 1'b1, 8'hFF, 22'h10);
    idle(3);
    check("drop_t4", {56'h0, drop_cnt}, {56'h0, cnt(1)[15:0]});
    check("acc_t4", {40'h0, acc_cnt}, {40'h0, cnt(4)});

    // Gap on idle bus: 7 IFG words
    for (int i = 0; i < 7; i++) exp_q.push_back(IFG);
    tick();
    req_gap = 1'b1;
    tick();
    req_gap = 1'b0;
    idle(12);

    // Gap held while full
    for (int i = 0; i < 7; i++) exp_q.push_back(IFG);
    tick();
    req_gap = 1'b1;
    full = 1'b1;
    tick();
    req_gap = 1'b0;
    repeat (3) tick();
    full = 1'b0;
    idle(12);

    // SOF after 3 IFG words takes priority; remaining 4 follow the TLP
    for (int i = 0; i < 3; i++) exp_q.push_back(IFG);
    exp_q.push_back(dw(64'hF100_000F_4000_0001, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'hCAFE_F00D_1234_5123, 1'b1, 8'hFF));
    for (int i = 0; i < 4; i++) exp_q.push_back(IFG);
    tick();
    req_gap = 1'b1;
    tick();
    req_gap = 1'b0;
    idle(2);
    beat(64'h0100_000F_4000_0001, 1'b0, 8'hFF, 22'h10);
    beat(64'hCAFE_F00D_0000_0123, 1'b1, 8'hFF, 22'h10);
    idle(10);
    check("acc_t5", {40'h0, acc_cnt}, {40'h0, cnt(5)});

    // Reset during DATA of a 6-beat TLP: tail ignored
    exp_q.push_back(dw(64'hF100_000F_4000_0004, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'hAAAA_0001_1234_5100, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'hAAAA_0002_BBBB_0002, 1'b0, 8'hFF));
    beat(64'h0100_000F_4000_0004, 1'b0, 8'hFF, 22'h10);
    beat(64'hAAAA_0001_0000_0100, 1'b0, 8'hFF, 22'h10);
    beat(64'hAAAA_0002_BBBB_0002, 1'b0, 8'hFF, 22'h10);
    beat(64'hAAAA_0003_BBBB_0003, 1'b0, 8'hFF, 22'h10);
    sys_rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_wr_en", {71'h0, wr_en}, 72'h0);
    check("rst_mid_din", din, 72'h0);
    check("rst_mid_drop", {56'h0, drop_cnt}, 72'h0);
    check("rst_mid_acc", {40'h0, acc_cnt}, 72'h0);
    sys_rst = 1'b0;
    put(64'hAAAA_0004_BBBB_0004, 1'b0, 8'hFF, 22'h10);
    beat(64'hAAAA_0005_BBBB_0005, 1'b1, 8'hFF, 22'h10);
    exp_q.push_back(dw(64'hF100_000F_4000_0001, 1'b0, 8'hFF));
    exp_q.push_back(dw(64'h0000_0000_1234_5ABC, 1'b1, 8'hFF));
    beat(64'h0100_000F_4000_0001, 1'b0, 8'hFF, 22'h10);
    beat(64'h0000_0000_0000_0ABC, 1'b1, 8'hFF, 22'h10);
    idle(4);
    check("acc_t6", {40'h0, acc_cnt}, {40'h0, cnt(1)});

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(posedge clk);
    check("pending_words", 72'(exp_q.size()), 72'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
